// File: rtl/dist_pkg.sv
// Shared definitions for the distance packet drain path: telegram framing
// constants, reader FSM states, captured packet descriptor and header mux.
package dist_pkg;

   localparam logic [15:0] SYNC_WORD    = 16'hA55A;
   localparam int          HDR_BYTES    = 9;
   localparam int          BYTES_PER_PT = 4;
   localparam int          MAX_PTS      = 256;
   localparam int          FIFO_DEPTH   = 4;
   localparam int          FIFO_W       = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAY,
      ST_CHK,
      ST_DRAIN
   } state_t;

   // Everything sampled alongside a make pulse; pts is already clamped.
   typedef struct packed {
      logic        bank;
      logic [15:0] pts;
      logic [15:0] scan;
      logic [7:0]  tel_no;
      logic [15:0] angle;
   } pkt_info_t;

   function automatic logic [15:0] clamp_pts(input logic [15:0] points);
      return (points > 16'(MAX_PTS)) ? 16'(MAX_PTS) : points;
   endfunction

   // Header byte by position, MSB-first for all multi-byte fields.
   function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input pkt_info_t info);
      logic [7:0] b;
      case (idx)
         4'd0:    b = SYNC_WORD[15:8];
         4'd1:    b = SYNC_WORD[7:0];
         4'd2:    b = info.tel_no;
         4'd3:    b = info.scan[15:8];
         4'd4:    b = info.scan[7:0];
         4'd5:    b = info.angle[15:8];
         4'd6:    b = info.angle[7:0];
         4'd7:    b = info.pts[15:8];
         4'd8:    b = info.pts[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/pkt_byte_fifo.sv
// Small synchronous FIFO holding tagged stream bytes ({sop, eop, data}).
// DEPTH must be a power of two so the pointers wrap naturally.
module pkt_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 10,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  pop_data,
   output logic [CW-1:0] count,
   output logic          empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Storage array; no reset needed, contents only observed when count > 0.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign pop_data = mem[rd_ptr];
   assign empty    = (count == '0);

endmodule

// File: rtl/dist_packet_reader.sv
// Drain side of the distance ping-pong RAM: frames header + payload + XOR
// checksum for each closed bank and streams it over valid/ready.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | nothing in progress; waits for make or a pending packet
//  ST_HDR   | pushing the 9 header bytes
//  ST_PAY   | issuing RAM reads; returned bytes pushed one cycle later
//  ST_CHK   | landing the last read, then pushing the checksum byte
//  ST_DRAIN | waiting for the FIFO to empty before the next telegram
module dist_packet_reader
   import dist_pkg::*;
(
   input  logic        i_clk_50m,
   input  logic        i_rst,
   input  logic        i_packet_make,
   input  logic        i_packet_pingpang,
   input  logic [15:0] i_packet_points,
   input  logic [15:0] i_scan_counter,
   input  logic [7:0]  i_telegram_no,
   input  logic [15:0] i_first_angle,
   output logic [10:0] o_packet_rdaddr,
   input  logic [7:0]  i_packet_rddata,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_tx_sop,
   output logic        o_tx_eop,
   output logic        o_busy,
   output logic        o_len_err,
   output logic [7:0]  o_drop_cnt
);

   state_t      state_q, state_d;
   pkt_info_t   cur, pend, mk;
   logic        pend_valid;
   logic        pend_take;
   logic [3:0]  hdr_idx;
   logic [10:0] rd_cnt;
   logic [10:0] n_bytes;
   logic        rd_vld;
   logic        rd_issue;
   logic [7:0]  csum;
   logic        enter_hdr;

   logic              push;
   logic [FIFO_W-1:0] push_data;
   logic              pop;
   logic [FIFO_W-1:0] head;
   logic [2:0]        fifo_count;
   logic              fifo_empty;
   logic [2:0]        occupancy;
   logic              room1;
   logic              room2;

   assign mk.bank   = i_packet_pingpang;
   assign mk.pts    = clamp_pts(i_packet_points);
   assign mk.scan   = i_scan_counter;
   assign mk.tel_no = i_telegram_no;
   assign mk.angle  = i_first_angle;

   assign n_bytes   = cur.pts[10:0] * 11'(BYTES_PER_PT);

   // Reads in flight hold a FIFO slot so returning RAM data never overflows.
   assign occupancy = fifo_count + {2'b00, rd_vld};
   assign room1     = (occupancy < 3'd4);
   assign room2     = (occupancy < 3'd3);
   assign enter_hdr = (state_d == ST_HDR) && (state_q != ST_HDR);

   // FSM state register.
   always_ff @(posedge i_clk_50m) begin
      if (i_rst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state, FIFO push selection and RAM read issue.
   always_comb begin
      state_d   = state_q;
      push      = 1'b0;
      push_data = '0;
      rd_issue  = 1'b0;
      pend_take = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pend_valid) begin
               pend_take = 1'b1;
               state_d   = ST_HDR;
            end else if (i_packet_make) begin
               state_d = ST_HDR;
            end
         end
         ST_HDR: begin
            if (room1) begin
               push      = 1'b1;
               push_data = {(hdr_idx == 4'd0), 1'b0, hdr_byte(hdr_idx, cur)};
               if (hdr_idx == 4'(HDR_BYTES - 1)) begin
                  if (n_bytes == 11'd0) begin
                     state_d = ST_CHK;
                  end else begin
                     // Fire the first read alongside the last header byte so
                     // the payload follows the header without a bubble.
                     rd_issue = room2;
                     state_d  = (room2 && n_bytes == 11'd1) ? ST_CHK : ST_PAY;
                  end
               end
            end
         end
         ST_PAY: begin
            if (rd_vld) begin
               push      = 1'b1;
               push_data = {2'b00, i_packet_rddata};
            end
            if (room1) begin
               rd_issue = 1'b1;
               if (rd_cnt == n_bytes - 11'd1) state_d = ST_CHK;
            end
         end
         ST_CHK: begin
            if (rd_vld) begin
               push      = 1'b1;
               push_data = {2'b00, i_packet_rddata};
            end else if (room1) begin
               push      = 1'b1;
               push_data = {1'b0, 1'b1, csum};
               state_d   = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) begin
               if (pend_valid) begin
                  pend_take = 1'b1;
                  state_d   = ST_HDR;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Make capture: current slot, single pending slot, or drop counter.
   always_ff @(posedge i_clk_50m) begin
      if (i_rst) begin
         cur        <= '0;
         pend       <= '0;
         pend_valid <= 1'b0;
         o_drop_cnt <= 8'd0;
         o_len_err  <= 1'b0;
      end else begin
         if (i_packet_make && (i_packet_points > 16'(MAX_PTS))) o_len_err <= 1'b1;
         if (pend_take) begin
            // Pending slot frees this cycle, so a coincident make refills it.
            cur        <= pend;
            pend_valid <= i_packet_make;
            if (i_packet_make) pend <= mk;
         end else if (i_packet_make) begin
            if (state_q == ST_IDLE) begin
               cur <= mk;
            end else if (!pend_valid) begin
               pend       <= mk;
               pend_valid <= 1'b1;
            end else if (o_drop_cnt != 8'hFF) begin
               o_drop_cnt <= o_drop_cnt + 8'd1;
            end
         end
      end
   end

   // Header/read counters, read-return tracking and running checksum.
   always_ff @(posedge i_clk_50m) begin
      if (i_rst) begin
         hdr_idx <= 4'd0;
         rd_cnt  <= 11'd0;
         rd_vld  <= 1'b0;
         csum    <= 8'd0;
      end else begin
         rd_vld <= rd_issue;
         if (enter_hdr) begin
            hdr_idx <= 4'd0;
            rd_cnt  <= 11'd0;
            csum    <= 8'd0;
         end else begin
            if (state_q == ST_HDR && push) hdr_idx <= hdr_idx + 4'd1;
            if (rd_issue) rd_cnt <= rd_cnt + 11'd1;
            if (push)     csum   <= csum ^ push_data[7:0];
         end
      end
   end

   pkt_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (FIFO_W)
   ) u_fifo (
      .clk       (i_clk_50m),
      .rst       (i_rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   assign pop             = !fifo_empty && i_tx_ready;
   assign o_tx_valid      = !fifo_empty;
   assign o_tx_data       = fifo_empty ? 8'h00 : head[7:0];
   assign o_tx_sop        = !fifo_empty && head[9];
   assign o_tx_eop        = !fifo_empty && head[8];
   assign o_packet_rdaddr = {cur.bank, rd_cnt[9:0]};
   assign o_busy          = (state_q != ST_IDLE) || pend_valid;

endmodule

// File: tb/tb_dist_packet_reader.sv
module tb_dist_packet_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        make;
   logic        bank;
   logic [15:0] points;
   logic [15:0] scan;
   logic [7:0]  tel;
   logic [15:0] angle;
   logic [10:0] rdaddr;
   logic [7:0]  rddata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx_sop;
   logic        tx_eop;
   logic        busy;
   logic        len_err;
   logic [7:0]  drop_cnt;

   always #10 clk = ~clk;

   dist_packet_reader dut (
      .i_clk_50m         (clk),
      .i_rst             (rst),
      .i_packet_make     (make),
      .i_packet_pingpang (bank),
      .i_packet_points   (points),
      .i_scan_counter    (scan),
      .i_telegram_no     (tel),
      .i_first_angle     (angle),
      .o_packet_rdaddr   (rdaddr),
      .i_packet_rddata   (rddata),
      .o_tx_data         (tx_data),
      .o_tx_valid        (tx_valid),
      .i_tx_ready        (tx_ready),
      .o_tx_sop          (tx_sop),
      .o_tx_eop          (tx_eop),
      .o_busy            (busy),
      .o_len_err         (len_err),
      .o_drop_cnt        (drop_cnt)
   );

   // RAM model with one-cycle read latency.
   logic [7:0] ram [0:2047];
   always @(posedge clk) rddata <= ram[rdaddr];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Stream monitor.
   logic [9:0] rx_q[$];
   logic [9:0] exp_q[$];
   int         eop_cnt, sop_cnt, gaps, addr_moves;
   bit         in_pkt, prev_stall, rnd_ready;
   logic [7:0] prev_data;

   initial begin
      in_pkt = 0; prev_stall = 0; eop_cnt = 0; sop_cnt = 0; gaps = 0; addr_moves = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_pkt     = 0;
            prev_stall = 0;
         end else begin
            if (prev_stall) begin
               check("stall_valid", {31'd0, tx_valid}, 32'd1);
               check("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (!rnd_ready && in_pkt && !tx_valid) gaps++;
            if (busy && rdaddr[9:0] != 10'd0) addr_moves++;
            if (tx_valid && tx_ready) begin
               rx_q.push_back({tx_sop, tx_eop, tx_data});
               if (tx_sop) begin in_pkt = 1; sop_cnt++; end
               if (tx_eop) begin in_pkt = 0; eop_cnt++; end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
         end
      end
   end

   // Sink ready: held high or random per cycle.
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Reference telegram: header, payload from RAM bank, XOR of everything before.
   task automatic add_exp(input logic b, input logic [15:0] p_in, input logic [7:0] t,
                          input logic [15:0] s, input logic [15:0] a);
      logic [15:0] p;
      logic [7:0]  hb [9];
      logic [7:0]  x;
      logic [7:0]  d;
      int          n;
      p  = (p_in > 16'd256) ? 16'd256 : p_in;
      hb = '{8'hA5, 8'h5A, t, s[15:8], s[7:0], a[15:8], a[7:0], p[15:8], p[7:0]};
      x  = 8'h00;
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back({(i == 0), 1'b0, hb[i]});
         x ^= hb[i];
      end
      n = int'(p) * 4;
      for (int j = 0; j < n; j++) begin
         d = ram[{b, 10'(j)}];
         exp_q.push_back({2'b00, d});
         x ^= d;
      end
      exp_q.push_back({2'b01, x});
   endtask

   task automatic clear_rx();
      rx_q.delete();
      exp_q.delete();
      eop_cnt = 0; sop_cnt = 0; gaps = 0; addr_moves = 0;
   endtask

   task automatic drive_make(input logic b, input logic [15:0] p, input logic [7:0] t,
                             input logic [15:0] s, input logic [15:0] a);
      make = 1'b1; bank = b; points = p; tel = t; scan = s; angle = a;
      @(posedge clk);
      #1;
      make = 1'b0;
   endtask

   task automatic wait_eops(input int target, input int budget);
      int c;
      c = 0;
      while (eop_cnt < target && c < budget) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("eop_timeout", {31'd0, (eop_cnt >= target)}, 32'd1);
   endtask

   task automatic compare_stream(input string name);
      int n;
      check({name, "_len"}, rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_byte%0d", name, i), {22'd0, rx_q[i]}, {22'd0, exp_q[i]});
   endtask

   typedef struct {
      logic        bank;
      logic [15:0] points;
      logic [7:0]  tel;
      logic [15:0] scan;
      logic [15:0] angle;
      bit          rnd;
      int          exp_len;
      bit          exp_err;
      bit          no_reads;
   } vec_t;

   vec_t vecs [6];

   initial begin
      vecs[0] = '{1'b1, 16'd3,   8'h07, 16'h1234, 16'h0100, 1'b0, 22,   1'b0, 1'b0};
      vecs[1] = '{1'b1, 16'd3,   8'h07, 16'h1234, 16'h0100, 1'b1, 22,   1'b0, 1'b0};
      vecs[2] = '{1'b0, 16'd0,   8'h21, 16'hBEEF, 16'h0ACE, 1'b0, 10,   1'b0, 1'b1};
      vecs[3] = '{1'b0, 16'd1,   8'h42, 16'h00FF, 16'hFF00, 1'b1, 14,   1'b0, 1'b0};
      vecs[4] = '{1'b1, 16'd256, 8'h99, 16'h8001, 16'h7FFE, 1'b1, 1034, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 16'd300, 8'hC3, 16'h0F0F, 16'h1111, 1'b0, 1034, 1'b1, 1'b0};

      for (int i = 0; i < 2048; i++) ram[i] = 8'((i * 29) ^ (i >> 3));

      rnd_ready = 0;
      rst = 1'b1; make = 1'b0; bank = 1'b0; points = '0; scan = '0; tel = '0; angle = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_valid",  {31'd0, tx_valid}, 32'd0);
      check("rst_sop",    {31'd0, tx_sop},   32'd0);
      check("rst_eop",    {31'd0, tx_eop},   32'd0);
      check("rst_data",   {24'd0, tx_data},  32'd0);
      check("rst_busy",   {31'd0, busy},     32'd0);
      check("rst_lenerr", {31'd0, len_err},  32'd0);
      check("rst_drop",   {24'd0, drop_cnt}, 32'd0);
      check("rst_rdaddr", {21'd0, rdaddr},   32'd0);

      // Table-driven single telegrams.
      for (int v = 0; v < 6; v++) begin
         clear_rx();
         rnd_ready = vecs[v].rnd;
         add_exp(vecs[v].bank, vecs[v].points, vecs[v].tel, vecs[v].scan, vecs[v].angle);
         check($sformatf("v%0d_model_len", v), exp_q.size(), vecs[v].exp_len);
         drive_make(vecs[v].bank, vecs[v].points, vecs[v].tel, vecs[v].scan, vecs[v].angle);
         check($sformatf("v%0d_lat1_valid", v), {31'd0, tx_valid}, 32'd0);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_lat2_valid", v), {31'd0, tx_valid}, 32'd1);
         check($sformatf("v%0d_lat2_sop", v),   {31'd0, tx_sop},   32'd1);
         wait_eops(1, 6000);
         repeat (3) @(posedge clk);
         #1;
         compare_stream($sformatf("v%0d", v));
         check($sformatf("v%0d_lenerr", v), {31'd0, len_err}, {31'd0, vecs[v].exp_err});
         check($sformatf("v%0d_busy_end", v), {31'd0, busy}, 32'd0);
         if (!vecs[v].rnd) check($sformatf("v%0d_gaps", v), gaps, 0);
         if (vecs[v].no_reads) check($sformatf("v%0d_addr_moves", v), addr_moves, 0);
      end

      // Three makes back to back: first runs, second queued, third dropped.
      clear_rx();
      rnd_ready = 0;
      add_exp(1'b0, 16'd2, 8'h01, 16'h0001, 16'h0010);
      add_exp(1'b1, 16'd1, 8'h02, 16'h0002, 16'h0020);
      make = 1'b1; bank = 1'b0; points = 16'd2; tel = 8'h01; scan = 16'h0001; angle = 16'h0010;
      @(posedge clk); #1;
      bank = 1'b1; points = 16'd1; tel = 8'h02; scan = 16'h0002; angle = 16'h0020;
      @(posedge clk); #1;
      bank = 1'b0; points = 16'd5; tel = 8'h03; scan = 16'h0003; angle = 16'h0030;
      @(posedge clk); #1;
      make = 1'b0;
      check("b2b_busy", {31'd0, busy}, 32'd1);
      wait_eops(2, 2000);
      repeat (40) @(posedge clk);
      #1;
      compare_stream("b2b");
      check("b2b_sops", sop_cnt, 2);
      check("b2b_eops", eop_cnt, 2);
      check("b2b_drop", {24'd0, drop_cnt}, 32'd1);
      check("b2b_lenerr_sticky", {31'd0, len_err}, 32'd1);
      check("b2b_busy_end", {31'd0, busy}, 32'd0);

      // Reset in the middle of a payload, then a clean telegram.
      clear_rx();
      drive_make(1'b0, 16'd50, 8'h33, 16'h4444, 16'h5555);
      for (int c = 0; c < 200 && rx_q.size() < 20; c++) begin
         @(posedge clk);
         #1;
      end
      check("mid_progress", {31'd0, (rx_q.size() >= 20)}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_valid",  {31'd0, tx_valid}, 32'd0);
      check("mid_rst_busy",   {31'd0, busy},     32'd0);
      check("mid_rst_drop",   {24'd0, drop_cnt}, 32'd0);
      check("mid_rst_lenerr", {31'd0, len_err},  32'd0);
      check("mid_rst_eop",    {31'd0, tx_eop},   32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      clear_rx();
      add_exp(1'b1, 16'd2, 8'h09, 16'hCAFE, 16'h0042);
      drive_make(1'b1, 16'd2, 8'h09, 16'hCAFE, 16'h0042);
      wait_eops(1, 500);
      repeat (3) @(posedge clk);
      #1;
      compare_stream("post_rst");
      check("post_rst_gaps", gaps, 0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
